// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: steers the HPS ioctl download stream into the arcade core.
// Index-0 bytes become req/ack writes into one of four ROM regions, index 254
// fills the DIP switch bank and index 1 selects the game. core_reset is held
// during a ROM download and for HOLD_CYCLES cycles after it ends.
// Optional build macro ROM_LOAD_CHECKSUM_EN adds a 16-bit csum output that
// sums every index-0 byte written to ROM.
module rom_load_ctrl #(
  parameter logic [15:0] R1_BASE     = 16'h4000,
  parameter logic [15:0] R2_BASE     = 16'h8000,
  parameter logic [15:0] R3_BASE     = 16'hA000,
  parameter logic [15:0] ROM_END     = 16'hC000,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [1:0]  mem_sel,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic [63:0] dsw,
  output logic [7:0]  game_id,
  output logic        core_reset,
  output logic        ovf_err
`ifdef ROM_LOAD_CHECKSUM_EN
  ,
  output logic [15:0] csum
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        ovf_q, ovf_d;
  logic [63:0] dsw_q, dsw_d;
  logic [7:0]  game_id_q, game_id_d;
  logic        dl0_q;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        core_reset_q, core_reset_d;

  logic        dl0, dl0_rise, in_range, rom_strobe, accept, drop, dsw_wr;
  logic [1:0]  dec_sel;
  logic [15:0] dec_off;

  assign dl0        = ioctl_download && (ioctl_index == 8'd0);
  assign dl0_rise   = dl0 && !dl0_q;
  // Anything in addr[26:16] is past the 64 KiB ROM window.
  assign in_range   = (ioctl_addr[26:16] == 11'd0) && (ioctl_addr[15:0] < ROM_END);
  assign rom_strobe = ioctl_wr && dl0;
  assign accept     = rom_strobe && in_range && (state_q == ST_IDLE);
  assign drop       = rom_strobe && (!in_range || (state_q == ST_WRITE));
  assign dsw_wr     = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[26:3] == 24'd0);

  // Region decode: pick the highest base not above the address, offset from it.
  always_comb begin
    dec_sel = 2'd0;
    dec_off = ioctl_addr[15:0];
    if (ioctl_addr[15:0] >= R3_BASE) begin
      dec_sel = 2'd3;
      dec_off = ioctl_addr[15:0] - R3_BASE;
    end else if (ioctl_addr[15:0] >= R2_BASE) begin
      dec_sel = 2'd2;
      dec_off = ioctl_addr[15:0] - R2_BASE;
    end else if (ioctl_addr[15:0] >= R1_BASE) begin
      dec_sel = 2'd1;
      dec_off = ioctl_addr[15:0] - R1_BASE;
    end
  end

  // Write FSM: capture an accepted byte, hold the request until ack.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WRITE;
          sel_d   = dec_sel;
          addr_d  = dec_off;
          data_d  = ioctl_dout;
        end
      end
      ST_WRITE: begin
        if (mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky drop flag: cleared when a new ROM download starts, a drop in the
  // same cycle still wins.
  always_comb begin
    ovf_d = dl0_rise ? 1'b0 : ovf_q;
    if (drop) ovf_d = 1'b1;
  end

  // Per-byte DIP latches, one lane per switch byte.
  for (genvar gi = 0; gi < 8; gi++) begin : g_dsw
    assign dsw_d[8*gi +: 8] = (dsw_wr && (ioctl_addr[2:0] == 3'(gi))) ?
                              ioctl_dout : dsw_q[8*gi +: 8];
  end

  // Game selector: last index-1 byte wins.
  always_comb begin
    game_id_d = game_id_q;
    if (ioctl_wr && (ioctl_index == 8'd1)) game_id_d = ioctl_dout;
  end

  // Core reset hold: the counter sits at HOLD_CYCLES during a ROM download, so
  // a download restarted mid-hold reloads it; it is frozen while a write is
  // still outstanding. Out of reset the core stays held until a download ends.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    core_reset_d = core_reset_q;
    if (dl0) begin
      hold_cnt_d   = HOLD_LOAD;
      core_reset_d = 1'b1;
    end else if (state_q == ST_WRITE) begin
      core_reset_d = 1'b1;
    end else if (hold_cnt_q != 8'd0) begin
      hold_cnt_d   = hold_cnt_q - 8'd1;
      core_reset_d = (hold_cnt_q != 8'd1);
    end
  end

  // State registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= 2'd0;
      addr_q       <= 16'd0;
      data_q       <= 8'd0;
      ovf_q        <= 1'b0;
      dsw_q        <= 64'd0;
      game_id_q    <= 8'd0;
      dl0_q        <= 1'b0;
      hold_cnt_q   <= 8'd0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ovf_q        <= ovf_d;
      dsw_q        <= dsw_d;
      game_id_q    <= game_id_d;
      dl0_q        <= dl0;
      hold_cnt_q   <= hold_cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // Running sum of completed ROM writes, restarted with each ROM download.
  always_comb begin
    csum_d = csum_q;
    if (dl0_rise) csum_d = 16'd0;
    else if ((state_q == ST_WRITE) && mem_ack) csum_d = csum_q + {8'd0, data_q};
  end

  // Checksum register.
  always_ff @(posedge clk_sys) begin
    if (reset) csum_q <= 16'd0;
    else       csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

  assign mem_req    = (state_q == ST_WRITE);
  assign ioctl_wait = (state_q == ST_WRITE);
  assign mem_sel    = sel_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign dsw        = dsw_q;
  assign game_id    = game_id_q;
  assign ovf_err    = ovf_q;
  assign core_reset = core_reset_q || dl0 || reset;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: directed download sequences, a behavioural model
// updated on each rising edge, and a per-cycle compare against it.
module tb_rom_load_ctrl;
  localparam int HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = 27'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        mem_ack = 1'b0;
  logic        ioctl_wait, mem_req, core_reset, ovf_err;
  logic [1:0]  mem_sel;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, game_id;
  logic [63:0] dsw;
`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] csum;
`endif

  always #5 clk_sys = ~clk_sys;

  rom_load_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_req(mem_req),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ack(mem_ack), .dsw(dsw), .game_id(game_id),
    .core_reset(core_reset), .ovf_err(ovf_err)
`ifdef ROM_LOAD_CHECKSUM_EN
    , .csum(csum)
`endif
  );

  int checks = 0;
  int failures = 0;
  int ack_delay = 3;
  bit ack_en = 1'b1;
  bit chk_en = 1'b0;
  logic [25:0] rec_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] bases [4] = '{16'h0000, 16'h4000, 16'h8000, 16'hA000};
  bit          m_busy = 0;
  logic [1:0]  m_sel = 0;
  logic [15:0] m_addr = 0;
  logic [7:0]  m_data = 0;
  bit          m_ovf = 0;
  logic [7:0]  m_dsw [8] = '{default: 8'd0};
  logic [7:0]  m_gid = 0;
  bit          m_seen = 0;   // an index-0 download has ended since reset
  int          m_low = 0;    // edges with ROM download low (not counting busy edges)
  bit          m_prev_dl0 = 0;

  initial begin
    bit dl0, rise, old_busy;
    int r;
    forever begin
      @(posedge clk_sys);
      if (reset) begin
        m_busy = 0; m_ovf = 0; m_gid = 0; m_seen = 0; m_low = 0; m_prev_dl0 = 0;
        for (int i = 0; i < 8; i++) m_dsw[i] = 8'd0;
      end else begin
        dl0 = ioctl_download && (ioctl_index == 8'd0);
        rise = dl0 && !m_prev_dl0;
        old_busy = m_busy;
        if (rise) m_ovf = 0;
        if (ioctl_wr && dl0) begin
          if (old_busy || ioctl_addr >= 27'h000C000) m_ovf = 1;
          else begin
            r = 0;
            for (int i = 1; i < 4; i++) if (ioctl_addr[15:0] >= bases[i]) r = i;
            m_busy = 1;
            m_sel = 2'(r);
            m_addr = ioctl_addr[15:0] - bases[r];
            m_data = ioctl_dout;
          end
        end
        if (old_busy && mem_ack) m_busy = 0;
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 27'd8) m_dsw[ioctl_addr[2:0]] = ioctl_dout;
        if (ioctl_wr && ioctl_index == 8'd1) m_gid = ioctl_dout;
        if (dl0) begin m_seen = 1; m_low = 0; end
        else if (m_seen && !old_busy && m_low < 1000) m_low++;
        m_prev_dl0 = dl0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic prev_req;
    logic exp_cr;
    prev_req = 1'b0;
    forever begin
      @(negedge clk_sys);
      #1;
      if (chk_en) begin
        exp_cr = reset || (ioctl_download && ioctl_index == 8'd0) || m_busy || !m_seen || (m_low < HOLD);
        chk("mem_req", mem_req, m_busy);
        chk("ioctl_wait", ioctl_wait, m_busy);
        if (m_busy) begin
          chk("mem_sel", mem_sel, m_sel);
          chk("mem_addr", mem_addr, m_addr);
          chk("mem_data", mem_data, m_data);
        end
        chk("ovf_err", ovf_err, m_ovf);
        chk("dsw", dsw, {m_dsw[7], m_dsw[6], m_dsw[5], m_dsw[4], m_dsw[3], m_dsw[2], m_dsw[1], m_dsw[0]});
        chk("game_id", game_id, m_gid);
        chk("core_reset", core_reset, exp_cr);
        if (mem_req && !prev_req) rec_q.push_back({mem_sel, mem_addr, mem_data});
        prev_req = mem_req;
      end
    end
  end

  // ---------------- ack responder ----------------
  initial begin
    int req_age;
    req_age = 0;
    forever begin
      @(negedge clk_sys);
      mem_ack = 1'b0;
      if (mem_req && ack_en) begin
        req_age++;
        if (req_age >= ack_delay) begin
          mem_ack = 1'b1;
          req_age = 0;
        end
      end else if (!mem_req) begin
        req_age = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!mem_req) break;
      @(negedge clk_sys);
    end
    chk("write_timeout", mem_req, 1'b0);
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [26:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    wait_idle();
  endtask

  // Drop the ROM download and count cycles until core_reset falls.
  task automatic measure_hold(output int k);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_sys);
      if (!core_reset) begin k = i; break; end
    end
  endtask

  initial begin
    int k;
    logic [25:0] w;
    repeat (2) @(negedge clk_sys);
    chk_en = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_dsw", dsw, 64'd0);
    chk("rst_game_id", game_id, 8'd0);
    chk("rst_ovf", ovf_err, 1'b0);
    chk("rst_mem_bus", {mem_sel, mem_addr, mem_data}, 26'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    chk("idle_core_reset", core_reset, 1'b1);

    // ROM bytes across region boundaries
    rec_q.delete();
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    wr_byte(8'd0, 27'h0003FFF, 8'hA1);
    wr_byte(8'd0, 27'h0004000, 8'hB2);
    wr_byte(8'd0, 27'h000A001, 8'hC3);
    chk("rec_count", rec_q.size(), 3);
    if (rec_q.size() == 3) begin
      w = rec_q[0]; chk("wr0", w, {2'd0, 16'h3FFF, 8'hA1});
      w = rec_q[1]; chk("wr1", w, {2'd1, 16'h0000, 8'hB2});
      w = rec_q[2]; chk("wr2", w, {2'd3, 16'h0001, 8'hC3});
    end
    measure_hold(k);
    chk("hold_len", k, 16);

    // out-of-range bytes
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    wr_byte(8'd0, 27'h000C000, 8'h11);
    wr_byte(8'd0, 27'h0010000, 8'h22);
    #1;
    chk("ovf_set", ovf_err, 1'b1);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    #1;
    chk("ovf_sticky", ovf_err, 1'b1);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    #1;
    chk("ovf_cleared", ovf_err, 1'b0);

    // strobe while a write is pending
    ack_en = 1'b0;
    @(negedge clk_sys);
    ioctl_addr = 27'h0000010; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_addr = 27'h0000011; ioctl_dout = 8'h77;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
    #1;
    chk("busy_ovf", ovf_err, 1'b1);
    chk("busy_req", mem_req, 1'b1);
    chk("busy_data", {mem_addr, mem_data}, {16'h0010, 8'h5A});
    ack_en = 1'b1;
    wait_idle();
    measure_hold(k);
    chk("hold_len2", k, 16);

    // DIP switches and game id
    @(negedge clk_sys);
    ioctl_index = 8'd254;
    ioctl_download = 1'b1;
    wr_byte(8'd254, 27'd0, 8'h12);
    wr_byte(8'd254, 27'd1, 8'h34);
    ioctl_index = 8'd1;
    wr_byte(8'd1, 27'd0, 8'h03);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    #1;
    chk("dsw_lo", dsw[15:0], 16'h3412);
    chk("game_id_val", game_id, 8'h03);
    chk("cfg_core_reset", core_reset, 1'b0);

    // checksum and reset during a write
    ack_delay = 1;
    @(negedge clk_sys);
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    wr_byte(8'd0, 27'd0, 8'hFF);
    wr_byte(8'd0, 27'd1, 8'h02);
`ifdef ROM_LOAD_CHECKSUM_EN
    #1;
    chk("csum", csum, 16'h0101);
`endif
    ack_en = 1'b0;
    @(negedge clk_sys);
    ioctl_addr = 27'd2; ioctl_dout = 8'h44; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    #1;
    chk("pre_rst_req", mem_req, 1'b1);
    reset = 1'b1;
    @(negedge clk_sys);
    #1;
    chk("rst_abandon_req", mem_req, 1'b0);
    chk("rst_abandon_cr", core_reset, 1'b1);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(negedge clk_sys);
    #1;
    chk("post_rst_cr", core_reset, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
